// File: rtl/frmclk_pkg.sv
// Shared definitions for the frame-clock generator.
//   lock_state_e : states of the lock FSM held in frmclk_div_gen
//   lock_cnt_w   : width of the settle counter for a given settle length
//   half_up      : ceil(ratio/2), the number of high cycles of a divided clock
package frmclk_pkg;

   typedef enum logic [1:0] {
      S_INIT   = 2'd0,
      S_SETTLE = 2'd1,
      S_LOCKED = 2'd2
   } lock_state_e;

   function automatic int unsigned lock_cnt_w(input int unsigned cycles);
      return $clog2(cycles);
   endfunction

   // Computed as floor(r/2) + lsb so that it cannot overflow for any ratio.
   function automatic logic [31:0] half_up(input logic [31:0] ratio);
      return (ratio >> 1) + {31'd0, ratio[0]};
   endfunction

endpackage

// File: rtl/frmclk_div_chan.sv
// One divider channel: counter, shadow ratio, and registered outputs.
//   clk_i, rst_ni    : reference clock, async active-low reset
//   init_i           : load shadow from div_i and clear counter (lock FSM init)
//   align_i          : load shadow from div_i and counter from phase_i
//   div_i, phase_i   : runtime divide ratio and align load value
//   outclk_o         : divided clock, high while counter < ceil(shadow/2)
//   outclk_en_o      : strobe while counter == 0
//   cfg_err_o        : shadow ratio below 2, channel parked
//   disturb_o        : this channel disturbs lock in the current cycle
module frmclk_div_chan
   import frmclk_pkg::*;
#(
   parameter int CNT_W    = 8,
   parameter int DIV_INIT = 3
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             init_i,
   input  logic             align_i,
   input  logic [CNT_W-1:0] div_i,
   input  logic [CNT_W-1:0] phase_i,
   output logic             outclk_o,
   output logic             outclk_en_o,
   output logic             cfg_err_o,
   output logic             disturb_o
);

   logic [CNT_W-1:0] c_q, c_d;
   logic [CNT_W-1:0] sh_q, sh_d;
   logic             outclk_q, outclk_d;
   logic             en_q, en_d;
   logic             err_q, err_d;
   logic             sh_low;
   logic             wrap;

   assign sh_low = (sh_q < CNT_W'(2));
   assign wrap   = (c_q == sh_q - CNT_W'(1));

   always_comb begin
      sh_d = sh_q;
      c_d  = c_q + CNT_W'(1);
      if (init_i) begin
         sh_d = div_i;
         c_d  = '0;
      end else if (align_i) begin
         // align wins over a coincident wrap; out-of-range phase parks at 0
         sh_d = div_i;
         c_d  = (phase_i >= div_i) ? '0 : phase_i;
      end else if (sh_low || wrap) begin
         // an invalid shadow re-samples div_i every cycle until it is usable
         sh_d = div_i;
         c_d  = '0;
      end
      // outputs are derived from the next state so they line up with c_q
      err_d    = (sh_d < CNT_W'(2));
      outclk_d = !err_d && (32'(c_d) < half_up(32'(sh_d)));
      en_d     = !err_d && (c_d == '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         c_q      <= '0;
         sh_q     <= CNT_W'(DIV_INIT);
         outclk_q <= 1'b0;
         en_q     <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         c_q      <= c_d;
         sh_q     <= sh_d;
         outclk_q <= outclk_d;
         en_q     <= en_d;
         err_q    <= err_d;
      end
   end

   assign disturb_o   = align_i || err_q || sh_low || (wrap && (div_i != sh_q));
   assign outclk_o    = outclk_q;
   assign outclk_en_o = en_q;
   assign cfg_err_o   = err_q;

endmodule

// File: rtl/frmclk_div_gen.sv
// Multi-channel frame-clock generator with common lock indication.
//   refclk_i    : reference clock, the only clock
//   rst_n_i     : async-assert active-low reset
//   div_i       : per-channel divide ratio, channel k at [k*CNT_W +: CNT_W]
//   phase_i     : per-channel counter load value applied on align_i
//   align_i     : single-cycle pulse realigning all channels
//   outclk_o    : divided clock waveforms
//   outclk_en_o : one-cycle strobes at counter 0
//   cfg_err_o   : per-channel shadow ratio below 2
//   locked_o    : all channels undisturbed for LOCK_CYCLES cycles
module frmclk_div_gen
   import frmclk_pkg::*;
#(
   parameter int NUM_CLOCKS  = 2,
   parameter int CNT_W       = 8,
   parameter int DIV_INIT    = 3,
   parameter int LOCK_CYCLES = 64
) (
   input  logic                        refclk_i,
   input  logic                        rst_n_i,
   input  logic [NUM_CLOCKS*CNT_W-1:0] div_i,
   input  logic [NUM_CLOCKS*CNT_W-1:0] phase_i,
   input  logic                        align_i,
   output logic [NUM_CLOCKS-1:0]       outclk_o,
   output logic [NUM_CLOCKS-1:0]       outclk_en_o,
   output logic [NUM_CLOCKS-1:0]       cfg_err_o,
   output logic                        locked_o
);

   localparam int SETTLE_W = lock_cnt_w(LOCK_CYCLES);
   localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(LOCK_CYCLES - 1);

   lock_state_e          state_q;
   logic [SETTLE_W-1:0]  settle_q;
   logic                 locked_q;
   logic [NUM_CLOCKS-1:0] disturb_vec;
   logic                 disturb;
   logic                 init_load;

   assign init_load = (state_q == S_INIT);

   for (genvar gi = 0; gi < NUM_CLOCKS; gi++) begin : g_chan
      frmclk_div_chan #(
         .CNT_W    (CNT_W),
         .DIV_INIT (DIV_INIT)
      ) u_chan (
         .clk_i       (refclk_i),
         .rst_ni      (rst_n_i),
         .init_i      (init_load),
         .align_i     (align_i),
         .div_i       (div_i[gi*CNT_W +: CNT_W]),
         .phase_i     (phase_i[gi*CNT_W +: CNT_W]),
         .outclk_o    (outclk_o[gi]),
         .outclk_en_o (outclk_en_o[gi]),
         .cfg_err_o   (cfg_err_o[gi]),
         .disturb_o   (disturb_vec[gi])
      );
   end

   assign disturb = |disturb_vec;

   // locked_q rises one cycle after entering S_LOCKED but falls on the same
   // edge that leaves it, so a disturbance is reflected immediately.
   always_ff @(posedge refclk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q  <= S_INIT;
         settle_q <= '0;
         locked_q <= 1'b0;
      end else begin
         case (state_q)
            S_INIT: begin
               state_q  <= S_SETTLE;
               settle_q <= '0;
               locked_q <= 1'b0;
            end
            S_SETTLE: begin
               locked_q <= 1'b0;
               if (disturb) begin
                  settle_q <= '0;
               end else if (settle_q == SETTLE_LAST) begin
                  if (!(|cfg_err_o)) state_q <= S_LOCKED;
               end else begin
                  settle_q <= settle_q + SETTLE_W'(1);
               end
            end
            S_LOCKED: begin
               if (disturb) begin
                  state_q  <= S_SETTLE;
                  settle_q <= '0;
                  locked_q <= 1'b0;
               end else begin
                  locked_q <= 1'b1;
               end
            end
            default: begin
               state_q  <= S_INIT;
               settle_q <= '0;
               locked_q <= 1'b0;
            end
         endcase
      end
   end

   assign locked_o = locked_q;

endmodule

// File: tb/tb_frmclk_div_gen.sv
// Directed bench for frmclk_div_gen with NUM_CLOCKS=2, CNT_W=8, LOCK_CYCLES=64.
// Outputs are sampled on the falling edge; inputs change on the falling edge.
module tb_frmclk_div_gen;

   logic        refclk = 1'b0;
   logic        rst_n;
   logic [15:0] div;
   logic [15:0] phase;
   logic        align;
   logic [1:0]  outclk;
   logic [1:0]  outclk_en;
   logic [1:0]  cfg_err;
   logic        locked;

   int checks   = 0;
   int failures = 0;

   always #5 refclk = ~refclk;

   frmclk_div_gen #(
      .NUM_CLOCKS  (2),
      .CNT_W       (8),
      .DIV_INIT    (3),
      .LOCK_CYCLES (64)
   ) dut (
      .refclk_i    (refclk),
      .rst_n_i     (rst_n),
      .div_i       (div),
      .phase_i     (phase),
      .align_i     (align),
      .outclk_o    (outclk),
      .outclk_en_o (outclk_en),
      .cfg_err_o   (cfg_err),
      .locked_o    (locked)
   );

   task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%b expected=%b at t=%0t", tag, obs, exp, $time);
      end
   endtask

   // div0=3, div1=6 from reset release; locked expected from cycle 66 on.
   task automatic run_from_reset(input string tag);
      int c0, c1;
      for (int n = 1; n <= 80; n++) begin
         @(negedge refclk);
         c0 = (n - 1) % 3;
         c1 = (n - 1) % 6;
         chk({tag, "_en"},   outclk_en, {c1 == 0, c0 == 0});
         chk({tag, "_clk"},  outclk,    {c1 < 3, c0 < 2});
         chk({tag, "_err"},  cfg_err,   2'b00);
         chk({tag, "_lock"}, {1'b0, locked}, {1'b0, n >= 66});
      end
   endtask

   initial begin
      int c0, c1;
      rst_n = 1'b0;
      div   = {8'd6, 8'd3};
      phase = 16'd0;
      align = 1'b0;

      // reset state
      repeat (3) @(negedge refclk);
      chk("rst_en",   outclk_en, 2'b00);
      chk("rst_clk",  outclk,    2'b00);
      chk("rst_err",  cfg_err,   2'b00);
      chk("rst_lock", {1'b0, locked}, 2'b00);

      // test 1: lock-up from reset
      rst_n = 1'b1;
      run_from_reset("t1");
      // now c0=1, c1=1

      // test 2: align with phase0=2, phase1=0
      phase = {8'd0, 8'd2};
      align = 1'b1;
      for (int m = 0; m <= 70; m++) begin
         @(negedge refclk);
         align = 1'b0;
         c0 = (2 + m) % 3;
         c1 = m % 6;
         chk("t2_en",   outclk_en, {c1 == 0, c0 == 0});
         chk("t2_clk",  outclk,    {c1 < 3, c0 < 2});
         chk("t2_lock", {1'b0, locked}, {1'b0, m >= 65});
      end
      // now c0=0, c1=4

      // test 3: div0 3->4 mid-period, takes effect on wrap at j=3
      div[7:0] = 8'd4;
      for (int j = 1; j <= 75; j++) begin
         @(negedge refclk);
         c0 = (j < 3) ? j : (j - 3) % 4;
         c1 = (4 + j) % 6;
         chk("t3_en",   outclk_en, {c1 == 0, c0 == 0});
         chk("t3_clk",  outclk,    {c1 < 3, c0 < 2});
         chk("t3_lock", {1'b0, locked}, {1'b0, (j < 3) || (j >= 68)});
      end
      // now c0=0, c1=1

      // test 4: div1=1 -> config error at the wrap (k=5), then restore div1=5
      div[15:8] = 8'd1;
      for (int k = 1; k <= 110; k++) begin
         @(negedge refclk);
         c0 = k % 4;
         if (k < 5) begin
            c1 = 1 + k;
            chk("t4_en",   outclk_en, {1'b0, c0 == 0});
            chk("t4_clk",  outclk,    {c1 < 3, c0 < 2});
            chk("t4_err",  cfg_err,   2'b00);
            chk("t4_lock", {1'b0, locked}, 2'b01);
         end else if (k <= 40) begin
            chk("t4_en",   outclk_en, {1'b0, c0 == 0});
            chk("t4_clk",  outclk,    {1'b0, c0 < 2});
            chk("t4_err",  cfg_err,   2'b10);
            chk("t4_lock", {1'b0, locked}, 2'b00);
            if (k == 40) div[15:8] = 8'd5;
         end else begin
            c1 = (k - 41) % 5;
            chk("t4_en",   outclk_en, {c1 == 0, c0 == 0});
            chk("t4_clk",  outclk,    {c1 < 3, c0 < 2});
            chk("t4_err",  cfg_err,   2'b00);
            chk("t4_lock", {1'b0, locked}, {1'b0, k >= 106});
         end
      end

      // test 5: align with out-of-range phase0=7, div0=3 -> c0 loads 0
      div[7:0] = 8'd3;
      phase    = {8'd0, 8'd7};
      align    = 1'b1;
      for (int m = 0; m <= 80; m++) begin
         @(negedge refclk);
         align = 1'b0;
         c0 = m % 3;
         c1 = m % 5;
         chk("t5_en",   outclk_en, {c1 == 0, c0 == 0});
         chk("t5_clk",  outclk,    {c1 < 3, c0 < 2});
         chk("t5_lock", {1'b0, locked}, {1'b0, m >= 65});
      end

      // test 6: asynchronous reset mid-period while locked
      #2;
      rst_n = 1'b0;
      #1;
      chk("t6_async_en",   outclk_en, 2'b00);
      chk("t6_async_clk",  outclk,    2'b00);
      chk("t6_async_lock", {1'b0, locked}, 2'b00);
      div   = {8'd6, 8'd3};
      phase = 16'd0;
      repeat (3) @(negedge refclk);
      chk("t6_hold_en",  outclk_en, 2'b00);
      chk("t6_hold_err", cfg_err,   2'b00);
      rst_n = 1'b1;
      run_from_reset("t6");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/frmclk_div_gen.md
Name: frmclk_div_gen

Overview:
- Parametrised, multi-channel frame-clock generator clocked by the reference clock.
- Each channel derives a divided clock waveform and a one-cycle enable strobe using a runtime divide ratio, for example 120 MHz / 3 = 40 MHz frame clock.
- Supports phase alignment of all channels to an external align pulse, and reports a common lock indication once all channels are stable.
- Sits between the reference-clock input and the frame-clocked GBT logic, replacing fixed single-output dividers.

Parameters:
- NUM_CLOCKS, 2, number of independent output channels.
- CNT_W, 8, counter and divide-ratio width per channel; maximum ratio is 2^CNT_W-1.
- DIV_INIT, 3, shadow divide ratio loaded at reset.
- LOCK_CYCLES, 64, number of settle cycles without disturbance before locked asserts; must be at least 2.

Ports:
- refclk  in  1  reference clock; the only clock.
- rst_n  in  1  reset, asynchronous assert, active-low.
- div  in  NUM_CLOCKS*CNT_W  per-channel divide ratio; channel k occupies bits [k*CNT_W +: CNT_W].
- phase  in  NUM_CLOCKS*CNT_W  per-channel counter load value applied on align.
- align  in  1  single-cycle pulse that realigns all channels.
- outclk  out  NUM_CLOCKS  divided clock waveforms.
- outclk_en  out  NUM_CLOCKS  one-cycle strobe when the channel counter equals 0.
- cfg_err  out  NUM_CLOCKS  channel shadow ratio is below 2.
- locked  out  1  all channels stable for LOCK_CYCLES cycles.

Behaviour:
- Reset values (rst_n=0): every counter 0, every shadow = DIV_INIT, outclk=0, outclk_en=0, cfg_err=0, locked=0, FSM in S_INIT.
- Per channel k:
  - Counter c_k runs over 0..sh_k-1, incrementing by 1 per refclk.
  - At c_k = sh_k-1 it wraps to 0. On wrap, sh_k reloads from div[k].
  - All outputs are registers computed from the next counter value, so they are coincident with c_k:
    - outclk_en[k]=1 exactly in cycles where c_k=0.
    - outclk[k]=1 while c_k < ceil(sh_k/2), computed in CNT_W+1 bits. For sh=3 the waveform is high 2 cycles, low 1; for sh=4 it is high 2, low 2.
- align pulse:
  - All sh_k load div[k] and all c_k load phase[k] in the same cycle; outputs follow the next cycle.
  - If phase[k] >= div[k], c_k loads 0.
  - align takes priority over a simultaneous wrap.
- Config error:
  - cfg_err[k]=1 while sh_k < 2. That channel holds c_k=0, outclk[k]=0 and outclk_en[k]=0.
  - The channel re-samples div[k] every cycle until the value is valid, then resumes from c_k=0.
- Lock FSM:
  - S_INIT: one cycle after reset release; all sh_k load div[k], c_k=0. Next state S_SETTLE.
  - S_SETTLE: settle counter counts from 0. When it reaches LOCK_CYCLES-1 and no cfg_err is set, go to S_LOCKED.
  - S_LOCKED: locked=1, registered, rising in the cycle after the transition.
- Lock disturbances (any of these):
  - align pulse;
  - a wrap reload that changes sh_k;
  - any cfg_err set.
- Disturbance handling:
  - In S_LOCKED, a disturbance moves the FSM to S_SETTLE, clears the settle counter, and drops locked the next cycle.
  - In S_SETTLE, a disturbance clears the settle counter.
  - align while locked always drops lock, even if phases are unchanged.
- Reset mid-operation: all state returns to reset values immediately, asynchronously. Release is synchronous to refclk; upstream synchronisation of rst_n is assumed.
- div changes mid-period take effect only at the next wrap or align. No glitch is permitted within a period.

Decomposition:
- Package frmclk_pkg:
  - lock FSM state enum (S_INIT, S_SETTLE, S_LOCKED);
  - function lock_cnt_w(LOCK_CYCLES) = $clog2 of LOCK_CYCLES;
  - function half_up(ratio) computing the ceil-half.
- Sub-module frmclk_div_chan:
  - one instance per channel, holding counter, shadow, outclk/outclk_en registers and cfg_err;
  - exports a disturbance flag.
- Top level:
  - holds the lock FSM;
  - ORs the per-channel disturbance flags.

Test Plan:
1. Reset, then div0=3, div1=6, LOCK_CYCLES=64:
   - outclk_en[0] pulses every 3 cycles and outclk[0] shows the 110 pattern;
   - outclk_en[1] pulses every 6 cycles and outclk[1] shows 111000;
   - locked rises 66 cycles after rst_n release (1 cycle S_INIT, 64 settle cycles, 1 registered output) and stays high.
2. Locked, then align with phase0=2, phase1=0:
   - the next cycle c0=2 and c1=0;
   - outclk_en[0] fires one cycle later;
   - locked drops one cycle after align and returns after the settle period.
3. Locked, change div0 from 3 to 4 mid-period:
   - the current 3-cycle period completes unchanged, then the 1100 pattern starts;
   - locked drops on that wrap and re-locks after the settle period.
4. Set div1=1:
   - at the next wrap cfg_err[1]=1 and outclk[1]/outclk_en[1] stay 0;
   - locked stays 0 indefinitely.
   - Restore div1=5: cfg_err clears, the channel runs period 5, and locked rises after the settle period.
5. align with phase0=7, div0=3: c0 loads 0 because phase is out of range, and outclk_en[0] asserts the cycle after align.
6. Assert rst_n=0 mid-period with locked=1: all outputs are 0 asynchronously within the same cycle; after release, test 1's timing repeats exactly.
